// File: rtl/led_fade_pkg.sv
// led_fade_pkg: shared constants for the LED afterglow fader.
//   LED_N        number of independent LED channels
//   PWM_BITS_DEF default brightness / PWM counter width
//   LEVEL_MAX    full-brightness level for the default width
package led_fade_pkg;
    localparam int LED_N = 16;
    localparam int PWM_BITS_DEF = 8;
    localparam logic [PWM_BITS_DEF-1:0] LEVEL_MAX = '1;
endpackage

// File: rtl/led_fade_chan.sv
// led_fade_chan: one LED channel -- brightness level, saturating decay, compare, output flop.
//   clk       clock, all state on posedge
//   rst       synchronous reset, active-low
//   led_i     raw LED request; loads full brightness
//   decay_i   decay step strobe, shared by all channels
//   pwm_cnt_i free-running PWM counter from the top
//   led_o     registered PWM output
// Build option: LED_FADE_GAMMA_EN selects a squared (gamma ~2) brightness curve.
module led_fade_chan import led_fade_pkg::*; #(
    parameter int PWM_BITS   = PWM_BITS_DEF,
    parameter int DECAY_STEP = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                led_i,
    input  logic                decay_i,
    input  logic [PWM_BITS-1:0] pwm_cnt_i,
    output logic                led_o
);
    localparam logic [PWM_BITS-1:0] MAX  = '1;
    localparam logic [PWM_BITS-1:0] STEP = PWM_BITS'(DECAY_STEP);

    logic [PWM_BITS-1:0] level_q, level_d, cmp;
    logic                led_q, led_d;

`ifdef LED_FADE_GAMMA_EN
    logic [2*PWM_BITS-1:0] prod;
    assign prod = {{PWM_BITS{1'b0}}, level_q} * {{PWM_BITS{1'b0}}, level_q};
    assign cmp  = PWM_BITS'(prod >> PWM_BITS);
`else
    assign cmp = level_q;
`endif

    // A lit input beats a coincident decay step; decay clamps at zero.
    always_comb begin
        level_d = led_i ? MAX : decay_i ? (level_q < STEP ? '0 : level_q - STEP) : level_q;
        // Full level is forced solid so the gamma curve cannot leave a dark slot.
        led_d   = (level_q == MAX) | (pwm_cnt_i < cmp);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            level_q <= '0;
            led_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            led_q   <= led_d;
        end
    end

    assign led_o = led_q;
endmodule

// File: rtl/led_fade.sv
// led_fade: 16-channel PWM LED fader giving a chaser pattern an afterglow trail.
//   clk        clock, all state on posedge
//   rst        synchronous reset, active-low
//   led_in     raw chaser pattern, bit i set = LED i lit
//   led_out    registered PWM-modulated pattern to the board LEDs
//   decay_tick registered one-cycle pulse marking each decay step
// Build option: LED_FADE_GAMMA_EN (see led_fade_chan) selects the gamma curve.
module led_fade import led_fade_pkg::*; #(
    parameter int          PWM_BITS   = PWM_BITS_DEF,
    parameter int unsigned DECAY_DIV  = 50000,
    parameter int          DECAY_STEP = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LED_N-1:0] led_in,
    output logic [LED_N-1:0] led_out,
    output logic             decay_tick
);
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [31:0]         div_cnt_q, div_cnt_d;
    logic                tick_q, tick_d;

    always_comb begin
        pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
        tick_d    = div_cnt_q == DECAY_DIV - 1;
        div_cnt_d = tick_d ? '0 : div_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pwm_cnt_q <= '0;
            div_cnt_q <= '0;
            tick_q    <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            div_cnt_q <= div_cnt_d;
            tick_q    <= tick_d;
        end
    end

    // Channels decay in the cycle the registered tick is high.
    for (genvar i = 0; i < LED_N; i++) begin : g_chan
        led_fade_chan #(
            .PWM_BITS  (PWM_BITS),
            .DECAY_STEP(DECAY_STEP)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .led_i    (led_in[i]),
            .decay_i  (tick_q),
            .pwm_cnt_i(pwm_cnt_q),
            .led_o    (led_out[i])
        );
    end

    assign decay_tick = tick_q;
endmodule

// File: tb/tb_led_fade.sv
// tb_led_fade: randomized and directed checks of led_fade against a cycle-level behavioural model.
module tb_led_fade;
    localparam int PB = 8, DIV = 4, STEP = 64, MAXL = 255;

    logic        clk = 1'b0, rst = 1'b0;
    logic [15:0] led_in = '0, led_out;
    logic        decay_tick;
    int          checks = 0, errors = 0;
    bit          chk_en = 1'b0;

    int          n_q;
    int          lvl[16];
    logic [15:0] exp_out;
    logic        exp_tick;

    led_fade #(.PWM_BITS(PB), .DECAY_DIV(DIV), .DECAY_STEP(STEP)) dut (
        .clk(clk), .rst(rst), .led_in(led_in), .led_out(led_out), .decay_tick(decay_tick)
    );

    always #5 clk = ~clk;

    function automatic int cmp_of(int l);
`ifdef LED_FADE_GAMMA_EN
        return (l * l) / 256;
`else
        return l;
`endif
    endfunction

    function automatic int fade(int l);
        return l >= STEP ? l - STEP : 0;
    endfunction

    // n_q = clock edges since reset release; pwm value = n_q mod 256,
    // tick high after every DIV-th edge, levels follow load/decay/hold rules.
    always @(posedge clk) begin
        if (!rst) begin
            n_q      <= 0;
            exp_tick <= 1'b0;
            exp_out  <= '0;
            for (int i = 0; i < 16; i++) lvl[i] <= 0;
        end else begin
            n_q      <= n_q + 1;
            exp_tick <= ((n_q + 1) % DIV) == 0;
            for (int i = 0; i < 16; i++) begin
                lvl[i]     <= led_in[i] ? MAXL : exp_tick ? fade(lvl[i]) : lvl[i];
                exp_out[i] <= (lvl[i] == MAXL) || ((n_q % 256) < cmp_of(lvl[i]));
            end
        end
    end

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, want);
        end
    endtask

    task automatic wait_tick(int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (decay_tick) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_tick: no decay_tick within %0d cycles", budget);
    endtask

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("led_out vs model", led_out, exp_out);
            check("decay_tick vs model", decay_tick, exp_tick);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cur, p1, p2;
        rst    = 1'b0;
        led_in = '1;
        @(negedge clk);
        chk_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("reset led_out", led_out, 0);
            check("reset decay_tick", decay_tick, 0);
            @(negedge clk);
        end
        rst = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) check("release latency 1", led_out, 16'h0000);
            if (k == 2) check("release latency 2", led_out, 16'hFFFF);
            check("first tick timing", decay_tick, k == 4);
        end

        // fade: tick is high now, pulse LED0 through it
        led_in = 16'h0001;
        @(negedge clk);
        led_in = '0;
        check("fade start level", lvl[0], 255);
        for (int k = 1; k <= 4; k++) begin
            wait_tick(2 * DIV);
            @(negedge clk);
            check("fade level", lvl[0], k < 4 ? 255 - 64 * k : 0);
        end
        @(negedge clk);
        for (int k = 0; k < 512; k++) begin
            check("saturated dark", led_out, 16'h0000);
            @(negedge clk);
        end

        // collision: led_in[3] held through a tick cycle
        led_in = 16'h0008;
        wait_tick(2 * DIV);
        @(negedge clk);
        led_in = '0;
        check("collision level", lvl[3], 255);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("collision solid", led_out[3], 1);
        end

        // chaser: one-hot rotating every 8 cycles
        for (int s = 0; s < 32; s++) begin
            cur    = s % 16;
            p1     = (cur + 15) % 16;
            p2     = (cur + 14) % 16;
            led_in = 16'(1 << cur);
            repeat (8) @(negedge clk);
            check("chaser current solid", led_out[cur], 1);
            check("chaser current level", lvl[cur], 255);
            if (s >= 2) begin
                check("chaser trail level p1", lvl[p1], 127);
                check("chaser trail level p2", lvl[p2], 0);
            end
        end

        // random patterns with occasional mid-fade resets
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 299) == 0) rst = 1'b0;
            else if (!rst && $urandom_range(0, 2) == 0) rst = 1'b1;
            if ($urandom_range(0, 7) == 0) led_in = 16'($urandom & $urandom & $urandom);
        end
        rst    = 1'b1;
        led_in = '0;
        repeat (20) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
